// File: rtl/muladd_pkg.sv
// Shared Q8.8 types and the dot_accum state encoding for the multiply-add pipeline.
package muladd_pkg;

    localparam int unsigned Q_W    = 16;
    localparam int unsigned Q_FRAC = 8;

    typedef logic signed [Q_W-1:0] q88_t;

    typedef enum logic [0:0] {
        ACCUM,
        HOLD
    } dacc_state_e;

endpackage

// File: rtl/sat_narrow.sv
// Narrows a wide signed accumulator to Q8.8 and flags out-of-range values.
// DOT_ACCUM_SAT_EN selects clamping; otherwise the low 16 bits wrap.
module sat_narrow
    import muladd_pkg::*;
#(
    parameter int unsigned ACC_W = 26
) (
    input  logic signed [ACC_W-1:0] acc_i,
    output q88_t                    sum_o,
    output logic                    ovf_o
);

    // In range iff every bit from the Q8.8 sign bit upward matches the MSB.
    assign ovf_o = (acc_i[ACC_W-1:Q_W-1] != {(ACC_W - Q_W + 1){acc_i[ACC_W-1]}});

`ifdef DOT_ACCUM_SAT_EN
    always_comb begin
        sum_o = acc_i[Q_W-1:0];
        if (ovf_o) begin
            sum_o = {acc_i[ACC_W-1], {(Q_W - 1){~acc_i[ACC_W-1]}}};
        end
    end
`else
    assign sum_o = acc_i[Q_W-1:0];
`endif

endmodule

// File: rtl/dot_accum.sv
// Reduces LEN consecutive Q8.8 partial sums into one Q8.8 dot-product result
// with valid/ready on both sides. Build option: DOT_ACCUM_SAT_EN (clamp on overflow).
module dot_accum
    import muladd_pkg::*;
#(
    parameter int unsigned LEN   = 4,
    parameter int unsigned ACC_W = 26
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [Q_W-1:0] in_sum,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [Q_W-1:0] out_sum,
    output logic           out_ovf
);

    localparam int unsigned CNT_W = (LEN > 1) ? $clog2(LEN) : 1;

    typedef logic signed [ACC_W-1:0] acc_t;

    dacc_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    acc_t             acc_q, acc_d;
    logic             out_valid_q, out_valid_d;
    q88_t             out_sum_q, out_sum_d;
    logic             out_ovf_q, out_ovf_d;

    q88_t  in_q;
    acc_t  acc_sum;
    q88_t  nar_sum;
    logic  nar_ovf;
    logic  accept;
    logic  xfer;
    logic  last;

    assign in_q     = in_sum;
    assign in_ready = (state_q == ACCUM) | out_ready;
    assign accept   = in_valid & in_ready;
    assign xfer     = out_valid_q & out_ready;
    assign last     = (cnt_q == CNT_W'(LEN - 1));

    // A count of zero marks the first partial of a result, which loads rather than adds.
    assign acc_sum = ((cnt_q == '0) ? acc_t'(0) : acc_q) + acc_t'(in_q);

    sat_narrow #(
        .ACC_W(ACC_W)
    ) u_narrow (
        .acc_i(acc_sum),
        .sum_o(nar_sum),
        .ovf_o(nar_ovf)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_ovf_d   = out_ovf_q;

        if (xfer) begin
            out_valid_d = 1'b0;
            state_d     = ACCUM;
        end

        if (accept) begin
            acc_d = acc_sum;
            if (last) begin
                cnt_d       = '0;
                out_sum_d   = nar_sum;
                out_ovf_d   = nar_ovf;
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            cnt_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_dot_accum.sv
// Randomized and directed checks of dot_accum (LEN=4 and LEN=1 instances)
// against a handshake-level reference model.
module tb_dot_accum;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [15:0] in_sum    [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [15:0] out_sum   [2];
    logic        out_ovf   [2];

    int n_vec = 0;
    int n_err = 0;

    // Reference model: partial count, exact running sum, pending result.
    int          len_m   [2] = '{4, 1};
    int          cnt_m   [2] = '{0, 0};
    longint      sum_m   [2] = '{0, 0};
    logic        pend_m  [2] = '{1'b0, 1'b0};
    logic [16:0] pval_m  [2];

    always #5 clk = ~clk;

    dot_accum #(.LEN(4), .ACC_W(26)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_sum(in_sum[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_sum(out_sum[0]), .out_ovf(out_ovf[0])
    );

    dot_accum #(.LEN(1), .ACC_W(16)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_sum(in_sum[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_sum(out_sum[1]), .out_ovf(out_ovf[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {ovf, out_sum} expected for an exact sum.
    function automatic logic [16:0] narrow(input longint s);
        logic        ovf;
        logic [15:0] v;
        ovf = (s > 32767) || (s < -32768);
        v   = s[15:0];
`ifdef DOT_ACCUM_SAT_EN
        if (ovf) v = (s < 0) ? 16'h8000 : 16'h7FFF;
`endif
        return {ovf, v};
    endfunction

    task automatic model_step(input int i);
        logic exp_ready;
        if (rst) begin
            cnt_m[i]  = 0;
            sum_m[i]  = 0;
            pend_m[i] = 1'b0;
            return;
        end
        exp_ready = !pend_m[i] || out_ready[i];
        check($sformatf("u%0d.in_ready", i), 32'(in_ready[i]), 32'(exp_ready));
        check($sformatf("u%0d.out_valid", i), 32'(out_valid[i]), 32'(pend_m[i]));
        if (pend_m[i]) begin
            check($sformatf("u%0d.out_sum", i), 32'(out_sum[i]), 32'(pval_m[i][15:0]));
            check($sformatf("u%0d.out_ovf", i), 32'(out_ovf[i]), 32'(pval_m[i][16]));
        end
        if (pend_m[i] && out_ready[i]) pend_m[i] = 1'b0;
        if (in_valid[i] && exp_ready) begin
            if (cnt_m[i] == 0) sum_m[i] = 0;
            sum_m[i] += longint'($signed(in_sum[i]));
            cnt_m[i]++;
            if (cnt_m[i] == len_m[i]) begin
                cnt_m[i]  = 0;
                pend_m[i] = 1'b1;
                pval_m[i] = narrow(sum_m[i]);
            end
        end
    endtask

    // Sample at the falling edge, return 1 time unit after the rising edge.
    task automatic cycle();
        @(negedge clk);
        for (int i = 0; i < 2; i++) model_step(i);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int i, input logic [15:0] v);
        in_valid[i] = 1'b1;
        in_sum[i]   = v;
        cycle();
        in_valid[i] = 1'b0;
    endtask

    initial begin
        logic [15:0] ovf_exp;
        for (int i = 0; i < 2; i++) begin
            in_valid[i]  = 1'b0;
            in_sum[i]    = '0;
            out_ready[i] = 1'b1;
        end
        @(posedge clk); #1;
        cycle();
        cycle();
        rst = 1'b0;
        @(negedge clk);
        check("rst.out_valid", 32'(out_valid[0]), 32'd0);
        check("rst.out_sum", 32'(out_sum[0]), 32'd0);
        check("rst.out_ovf", 32'(out_ovf[0]), 32'd0);
        check("rst.in_ready", 32'(in_ready[0]), 32'd1);
        @(posedge clk); #1;

        // Four ones -> 4.0, visible right after the fourth accept.
        for (int k = 0; k < 4; k++) send(0, 16'h0100);
        check("t1.valid", 32'(out_valid[0]), 32'd1);
        check("t1.sum", 32'(out_sum[0]), 32'h0400);
        check("t1.ovf", 32'(out_ovf[0]), 32'd0);

        send(0, 16'hFF00); send(0, 16'hFF00); send(0, 16'h0080); send(0, 16'h0080);
        check("t2.sum", 32'(out_sum[0]), 32'hFF00);
        check("t2.ovf", 32'(out_ovf[0]), 32'd0);

        for (int k = 0; k < 4; k++) send(0, 16'h7000);
`ifdef DOT_ACCUM_SAT_EN
        ovf_exp = 16'h7FFF;
`else
        ovf_exp = 16'hC000;
`endif
        check("t3.sum", 32'(out_sum[0]), 32'(ovf_exp));
        check("t3.ovf", 32'(out_ovf[0]), 32'd1);
        cycle();

        // Backpressure: result held while in_ready follows out_ready.
        out_ready[0] = 1'b0;
        for (int k = 0; k < 4; k++) send(0, 16'h0100);
        in_valid[0] = 1'b1;
        in_sum[0]   = 16'h0200;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("bp.sum", 32'(out_sum[0]), 32'h0400);
            check("bp.in_ready", 32'(in_ready[0]), 32'd0);
        end
        out_ready[0] = 1'b1;
        cycle();
        check("bp.xfer_valid", 32'(out_valid[0]), 32'd0);
        in_valid[0] = 1'b0;
        for (int k = 0; k < 3; k++) send(0, 16'h0100);
        check("bp.next_sum", 32'(out_sum[0]), 32'h0500);
        cycle();

        // Reset mid-accumulation discards the partial result.
        send(0, 16'h0100); send(0, 16'h0100);
        rst = 1'b1;
        in_valid[0] = 1'b1;
        cycle();
        rst = 1'b0;
        in_valid[0] = 1'b0;
        check("mr.valid", 32'(out_valid[0]), 32'd0);
        check("mr.sum", 32'(out_sum[0]), 32'd0);
        for (int k = 0; k < 4; k++) send(0, 16'h0100);
        check("mr.sum_after", 32'(out_sum[0]), 32'h0400);
        cycle();

        // LEN=1: one result per cycle, back to back.
        for (int k = 1; k <= 3; k++) begin
            in_valid[1] = 1'b1;
            in_sum[1]   = 16'(k * 256);
            cycle();
            check("len1.valid", 32'(out_valid[1]), 32'd1);
            check("len1.sum", 32'(out_sum[1]), 32'(k * 256));
        end
        in_valid[1] = 1'b0;
        cycle();

        // Random traffic on both instances, occasional reset.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                in_valid[i]  = ($urandom_range(0, 3) != 0);
                out_ready[i] = ($urandom_range(0, 3) != 0);
                in_sum[i]    = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 65535))
                                                           : 16'($signed($urandom_range(0, 1023)) - 512);
            end
            rst = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b1;
        end
        cycle();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dot_accum.md
# dot_accum

Downstream accumulator for the 4-lane Q8.8 multiply-add stage. Consumes the stage's 16-bit partial sums, adds `LEN` consecutive partials into a wide signed accumulator, and emits one 16-bit Q8.8 dot-product result per `LEN` inputs. Both sides use a valid/ready handshake, so vectors longer than four elements can be reduced without stalling the multiply-add stage unnecessarily.

## Interface
- `LEN`, default 4: partials per result; legal range 1..256.
- `ACC_W`, default 26: signed accumulator width; must be ≥ 16 + ceil(log2 LEN).
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `in_sum` is valid.
- `in_ready`  out  1  block accepts `in_sum` this cycle.
- `in_sum`  in  16  signed Q8.8 partial sum from the multiply-add stage.
- `out_valid`  out  1  `out_sum` and `out_ovf` hold a result.
- `out_ready`  in  1  consumer takes the result this cycle.
- `out_sum`  out  16  signed Q8.8 dot-product result.
- `out_ovf`  out  1  result exceeded the 16-bit signed range.

## Operation
- Accept condition: an input is accepted when `in_valid & in_ready` are both high.
- Output transfer condition: a result is transferred when `out_valid & out_ready` are both high.
- States:
  - ACCUM: collecting partials. `in_ready` = 1.
  - HOLD: result presented. `in_ready` = `out_ready`; this is a combinational path.
- Accumulation:
  - Each accepted `in_sum` is sign-extended to `ACC_W` and added to `acc`.
  - The first accepted input after reset or after a completed result loads `acc` = sext(`in_sum`) instead of adding.
  - `cnt` counts accepted inputs, 0..LEN-1.
- On the accept where `cnt` == LEN-1:
  - Register `out_sum` and `out_ovf` from acc + sext(in_sum).
  - Set `out_valid`, clear `cnt`, go to HOLD.
- In HOLD, when the output transfer condition holds:
  - With no accept in the same cycle: clear `out_valid`, go to ACCUM.
  - With an accept in the same cycle: that input starts the next result (`acc` loaded, `cnt` = 1). If LEN == 1, stay in HOLD and register the new result instead.
- Width rule: `out_ovf` = 1 when the full sum is outside [-32768, 32767]. The value of `out_sum` in that case is set under Configuration.
- `in_valid` gaps have no effect on the result; only accepted inputs count.

## Timing
- Latency: the result appears 1 cycle after the final partial is accepted.
- Throughput: one result per `LEN` accepted inputs, with no bubble when `out_ready` is held high.
- `out_sum` and `out_ovf` are stable while `out_valid` is high and `out_ready` is low.
- Reset values:
  - `out_valid` = 0, `out_sum` = 0, `out_ovf` = 0.
  - `acc` = 0, `cnt` = 0, state ACCUM.
  - `in_ready` = 1 from the first cycle after reset.
- Reset mid-accumulation or in HOLD discards the partial result or the pending output with no transfer.
- Reset has priority over a simultaneous accept or output transfer.

## Configuration
- `DOT_ACCUM_SAT_EN` defined: an out-of-range result clamps `out_sum` to 0x7FFF (positive) or 0x8000 (negative).
- `DOT_ACCUM_SAT_EN` undefined: `out_sum` = acc[15:0] (wrap-around).
- `out_ovf` behaves identically in both builds.

## Structure
- Shared package `muladd_pkg` holds:
  - `Q_W` = 16, `Q_FRAC` = 8.
  - typedef `q88_t` (signed 16-bit).
  - The state enum `dacc_state_e` {ACCUM, HOLD}.
- One sub-module, `sat_narrow`: ACC_W-bit signed input, 16-bit output plus overflow flag. It contains the saturating/wrapping logic selected by `DOT_ACCUM_SAT_EN`.

## Test plan
- LEN=4, `out_ready`=1, four accepts of 0x0100 → `out_sum`=0x0400, `out_ovf`=0, `out_valid` 1 cycle after the 4th accept.
- LEN=4, inputs 0xFF00, 0xFF00, 0x0080, 0x0080 → `out_sum`=0xFF00 (-1.0), `out_ovf`=0.
- LEN=4, four inputs of 0x7000 → `out_ovf`=1. With `DOT_ACCUM_SAT_EN`, `out_sum`=0x7FFF; without it, `out_sum`=0xC000.
- Backpressure: after a result, hold `out_ready`=0 for 5 cycles → `out_sum` stable and `in_ready`=0. Then set `out_ready`=1 with `in_valid`=1 and `in_sum`=0x0200 → transfer and accept in the same cycle; the next result after three more 0x0100 inputs is 0x0500.
- Assert `rst` after 2 of 4 accepts (0x0100 each), then 4 accepts of 0x0100 → `out_sum`=0x0400; no output during or before the reset.
- LEN=1, `in_valid` high every cycle with values 1, 2, 3 (×0x0100) → `out_sum` sequence 0x0100, 0x0200, 0x0300 on consecutive cycles.
